pipeline_ctrl: RTL and testbench

Central hazard and stall controller for the five-stage pipeline. Every cycle it decides which pipeline registers (if_id, id_ex, ex_mem, mem_wb) hold, which get zeroed control bits, and when the PC is redirected. It owns a small FSM that freezes the whole pipeline for the fixed-latency data-memory miss sequence. It is purely a controller: it stores no datapath values, only its own state, counter and optional performance counters.

---
 rtl/pipeline_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl
//
// Central hazard and stall controller for the five-stage pipeline. Each cycle
// it decides which pipeline registers hold, which get zeroed control bits, and
// when the PC is redirected. A small FSM freezes the whole pipeline for the
// fixed-latency data-memory miss sequence. No datapath values are stored.
//
// Optional feature macro: PIPELINE_CTRL_PERF_EN
//   When defined, adds the wrapping performance counters perfStallCycles,
//   perfFlushes and perfMisses. When undefined those ports do not exist.
//
// Parameters
//   MISS_LATENCY   cycles spent in MISS before the fill cycle (1..255)
//
// Ports
//   clock, reset          pipeline clock; asynchronous active-high reset
//   id_rs, id_rt          source fields of the instruction in ID
//   id_usesRt             ID instruction reads rt as a source
//   idEx_memRead, idEx_rd load flag and destination of the instruction in EX
//   ex_pcSrc              branch/jump in EX resolved taken
//   mem_memRead/Write     instruction in MEM accesses data memory
//   mem_hit               data memory hit for the current MEM access
//   stallIf..stallMem     hold the corresponding pipeline register
//   bubbleEx              load zeros into id_ex control bits
//   flushId, flushEx      kill younger instructions in if_id / id_ex
//   pcRedirect            PC takes the branch target
//   memFill               one-cycle fill strobe to data memory
//   busy                  FSM not in RUN
//   perf* (optional)      stall-cycle, flush and miss event counters
//
// FSM states
//   state | meaning
//   RUN   | normal operation, hazards resolved combinationally
//   MISS  | pipeline frozen, counting down the miss latency
//   FILL  | pipeline frozen, memFill strobe asserted for this one cycle
// -----------------------------------------------------------------------------
module pipeline_ctrl #(
    parameter int unsigned MISS_LATENCY = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_usesRt,
    input  logic        idEx_memRead,
    input  logic [4:0]  idEx_rd,
    input  logic        ex_pcSrc,
    input  logic        mem_memRead,
    input  logic        mem_memWrite,
    input  logic        mem_hit,
    output logic        stallIf,
    output logic        stallId,
    output logic        stallEx,
    output logic        stallMem,
    output logic        bubbleEx,
    output logic        flushId,
    output logic        flushEx,
    output logic        pcRedirect,
    output logic        memFill,
    output logic        busy
`ifdef PIPELINE_CTRL_PERF_EN
    ,
    output logic [31:0] perfStallCycles,
    output logic [31:0] perfFlushes,
    output logic [15:0] perfMisses
`endif
);

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_MISS = 2'd1,
        S_FILL = 2'd2
    } state_t;

    // Counter reload: MISS is entered with this value and leaves once it hits 0,
    // which yields exactly MISS_LATENCY cycles spent in MISS.
    localparam logic [7:0] CNT_INIT = 8'(MISS_LATENCY - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       memFill_q, memFill_d;
    logic       busy_q, busy_d;

    logic miss;
    logic freeze;
    logic load_use;
    logic lu_stall;

    always_comb begin
        miss     = (mem_memRead | mem_memWrite) & ~mem_hit;
        // Outside RUN the frozen pipeline keeps presenting the MEM access, so the
        // freeze does not depend on miss there.
        freeze   = (state_q != S_RUN) | miss;
        load_use = idEx_memRead & (idEx_rd != 5'd0) &
                   ((idEx_rd == id_rs) | (id_usesRt & (idEx_rd == id_rt)));
        // A taken branch kills the dependent instruction anyway, so it wins.
        lu_stall = ~freeze & ~ex_pcSrc & load_use;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_RUN: begin
                if (miss) begin
                    state_d = S_MISS;
                    cnt_d   = CNT_INIT;
                end
            end
            S_MISS: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                state_d = S_RUN;
            end
            default: begin
                state_d = S_RUN;
                cnt_d   = 8'd0;
            end
        endcase
        memFill_d = (state_d == S_FILL);
        busy_d    = (state_d != S_RUN);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_RUN;
            cnt_q     <= 8'd0;
            memFill_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            memFill_q <= memFill_d;
            busy_q    <= busy_d;
        end
    end

    assign stallIf    = freeze | lu_stall;
    assign stallId    = freeze | lu_stall;
    assign stallEx    = freeze;
    assign stallMem   = freeze;
    assign bubbleEx   = lu_stall;
    assign flushId    = ~freeze & ex_pcSrc;
    assign flushEx    = ~freeze & ex_pcSrc;
    assign pcRedirect = ~freeze & ex_pcSrc;
    assign memFill    = memFill_q;
    assign busy       = busy_q;

`ifdef PIPELINE_CTRL_PERF_EN
    logic [31:0] perfStallCycles_q;
    logic [31:0] perfFlushes_q;
    logic [15:0] perfMisses_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perfStallCycles_q <= 32'd0;
            perfFlushes_q     <= 32'd0;
            perfMisses_q      <= 16'd0;
        end else begin
            if (stallIf) begin
                perfStallCycles_q <= perfStallCycles_q + 32'd1;
            end
            if (pcRedirect) begin
                perfFlushes_q <= perfFlushes_q + 32'd1;
            end
            if ((state_q == S_RUN) && miss) begin
                perfMisses_q <= perfMisses_q + 16'd1;
            end
        end
    end

    assign perfStallCycles = perfStallCycles_q;
    assign perfFlushes     = perfFlushes_q;
    assign perfMisses      = perfMisses_q;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

    // Output vector bit order:
    // [9]stallIf [8]stallId [7]stallEx [6]stallMem [5]bubbleEx
    // [4]flushId [3]flushEx [2]pcRedirect [1]memFill [0]busy
    localparam logic [9:0] O_NONE = 10'b00_0000_0000;
    localparam logic [9:0] O_LU   = 10'b11_0010_0000;
    localparam logic [9:0] O_BR   = 10'b00_0001_1100;
    localparam logic [9:0] O_FRZ  = 10'b11_1100_0000;
    localparam logic [9:0] O_MISS = 10'b11_1100_0001;
    localparam logic [9:0] O_FILL = 10'b11_1100_0011;

    logic       clock = 1'b0;
    logic       reset;
    logic [4:0] id_rs, id_rt, idEx_rd;
    logic       id_usesRt, idEx_memRead, ex_pcSrc;
    logic       mem_memRead, mem_memWrite, mem_hit;

    logic s0_if, s0_id, s0_ex, s0_mem, b0, fi0, fe0, pr0, mf0, bz0;
    logic s1_if, s1_id, s1_ex, s1_mem, b1, fi1, fe1, pr1, mf1, bz1;
`ifdef PIPELINE_CTRL_PERF_EN
    logic [31:0] pst0, pfl0, pst1, pfl1;
    logic [15:0] pms0, pms1;
`endif

    always #5 clock = ~clock;

    pipeline_ctrl #(.MISS_LATENCY(4)) dut0 (
        .clock(clock), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_usesRt(id_usesRt),
        .idEx_memRead(idEx_memRead), .idEx_rd(idEx_rd), .ex_pcSrc(ex_pcSrc),
        .mem_memRead(mem_memRead), .mem_memWrite(mem_memWrite), .mem_hit(mem_hit),
        .stallIf(s0_if), .stallId(s0_id), .stallEx(s0_ex), .stallMem(s0_mem),
        .bubbleEx(b0), .flushId(fi0), .flushEx(fe0), .pcRedirect(pr0),
        .memFill(mf0), .busy(bz0)
`ifdef PIPELINE_CTRL_PERF_EN
        , .perfStallCycles(pst0), .perfFlushes(pfl0), .perfMisses(pms0)
`endif
    );

    pipeline_ctrl #(.MISS_LATENCY(1)) dut1 (
        .clock(clock), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_usesRt(id_usesRt),
        .idEx_memRead(idEx_memRead), .idEx_rd(idEx_rd), .ex_pcSrc(ex_pcSrc),
        .mem_memRead(mem_memRead), .mem_memWrite(mem_memWrite), .mem_hit(mem_hit),
        .stallIf(s1_if), .stallId(s1_id), .stallEx(s1_ex), .stallMem(s1_mem),
        .bubbleEx(b1), .flushId(fi1), .flushEx(fe1), .pcRedirect(pr1),
        .memFill(mf1), .busy(bz1)
`ifdef PIPELINE_CTRL_PERF_EN
        , .perfStallCycles(pst1), .perfFlushes(pfl1), .perfMisses(pms1)
`endif
    );

    logic [9:0] obs0, obs1;
    assign obs0 = {s0_if, s0_id, s0_ex, s0_mem, b0, fi0, fe0, pr0, mf0, bz0};
    assign obs1 = {s1_if, s1_id, s1_ex, s1_mem, b1, fi1, fe1, pr1, mf1, bz1};

    typedef struct {
        string      tag;
        bit         sel;
        logic [9:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  n_assert = 0;
    int  n_fail   = 0;

    task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                          input logic ldex, input logic [4:0] rd, input logic br,
                          input logic mrd, input logic mwr, input logic hit);
        id_rs = rs; id_rt = rt; id_usesRt = urt;
        idEx_memRead = ldex; idEx_rd = rd; ex_pcSrc = br;
        mem_memRead = mrd; mem_memWrite = mwr; mem_hit = hit;
    endtask

    task automatic push_exp(input string tag, input bit sel, input logic [9:0] e);
        sb_t it;
        it.tag = tag; it.sel = sel; it.exp = e;
        sb_q.push_back(it);
    endtask

    // Pop the oldest expectation and compare it with the selected DUT now.
    task automatic check_now();
        sb_t        it;
        logic [9:0] obs;
        if (sb_q.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL scoreboard_empty observed=none expected=entry");
        end else begin
            it  = sb_q.pop_front();
            obs = it.sel ? obs1 : obs0;
            n_assert++;
            assert (obs === it.exp) else begin
                n_fail++;
                $error("FAIL %s observed=%b expected=%b", it.tag, obs, it.exp);
            end
        end
    endtask

    // One clock cycle: expectation queued with the stimulus, checked mid-cycle.
    task automatic cyc(input string tag, input bit sel, input logic [9:0] e);
        push_exp(tag, sel, e);
        @(negedge clock);
        check_now();
        @(posedge clock);
        #1;
    endtask

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] e);
        n_assert++;
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, e);
        end
    endtask

    initial begin
        reset = 1'b1;
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        push_exp("reset_dut0", 1'b0, O_NONE); check_now();
        push_exp("reset_dut1", 1'b1, O_NONE); check_now();
`ifdef PIPELINE_CTRL_PERF_EN
        check_val("reset_perf_misses", 32'(pms0), 32'd0);
`endif
        @(posedge clock); #1;
        reset = 1'b0;

        cyc("idle", 1'b0, O_NONE);

        // Load-use through rs, then the load moves on and the hazard clears.
        set_in(5'd5, 5'd9, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc("lu_rs", 1'b0, O_LU);
        set_in(5'd5, 5'd9, 1'b0, 1'b0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b1);
        cyc("lu_rs_clear", 1'b0, O_NONE);

        // Load-use through rt only when rt is a source.
        set_in(5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc("lu_rt", 1'b0, O_LU);
        set_in(5'd3, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc("lu_rt_unused", 1'b0, O_NONE);

        // Destination $0 never triggers load-use.
        set_in(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc("lu_r0", 1'b0, O_NONE);

        // Branch wins over a simultaneous load-use.
        set_in(5'd5, 5'd9, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc("branch_over_lu", 1'b0, O_BR);

        // Miss (latency 4) with a taken branch held in EX throughout.
        set_in(5'd1, 5'd2, 1'b0, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc("miss4_c0", 1'b0, O_FRZ);
        cyc("miss4_c1", 1'b0, O_MISS);
        cyc("miss4_c2", 1'b0, O_MISS);
        cyc("miss4_c3", 1'b0, O_MISS);
        cyc("miss4_c4", 1'b0, O_MISS);
        cyc("miss4_c5_fill", 1'b0, O_FILL);
        mem_hit = 1'b1;
        cyc("miss4_c6_branch", 1'b0, O_BR);
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc("after_miss4", 1'b0, O_NONE);
`ifdef PIPELINE_CTRL_PERF_EN
        check_val("perf_stall_cycles", pst0, 32'd8);
        check_val("perf_flushes", pfl0, 32'd2);
        check_val("perf_misses", 32'(pms0), 32'd1);
`endif

        // Write miss, then async reset while MISS holds cnt=2.
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc("wmiss_c0", 1'b0, O_FRZ);
        cyc("wmiss_c1", 1'b0, O_MISS);
        push_exp("wmiss_c2_before_reset", 1'b0, O_MISS);
        check_now();
        #2;
        reset = 1'b1;
        mem_memWrite = 1'b0;
        mem_hit = 1'b1;
        #1;
        push_exp("async_reset_in_miss", 1'b0, O_NONE);
        check_now();
`ifdef PIPELINE_CTRL_PERF_EN
        check_val("perf_misses_after_reset", 32'(pms0), 32'd0);
        check_val("perf_stalls_after_reset", pst0, 32'd0);
`endif
        @(posedge clock); #1;
        reset = 1'b0;
        cyc("post_reset_idle", 1'b0, O_NONE);

        // Miss with latency 1: frozen three cycles, fill in cycle 2.
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("miss1_c0", 1'b1, O_FRZ);
        cyc("miss1_c1", 1'b1, O_MISS);
        cyc("miss1_c2_fill", 1'b1, O_FILL);
        mem_hit = 1'b1;
        cyc("miss1_c3_run", 1'b1, O_NONE);

        if (sb_q.size() != 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
